// File: rtl/vga_fb_arbiter.sv
// Shares one single-port frame-buffer RAM between display scan-out (priority) and a host draw/readback port.
// Latency: grant is combinational, the RAM access is issued the next cycle, and read data returns 2 cycles after grant.
// Backpressure: a requester holds its request until granted; a saturating wait counter forces a host grant after MAX_WAIT denials.
module vga_fb_arbiter #(
    parameter int AW       = 15,
    parameter int DW       = 3,
    parameter int MAX_WAIT = 4
) (
    input  logic          clk_in,
    input  logic          reset_in,
    input  logic          disp_req,
    input  logic [AW-1:0] disp_addr,
    output logic          disp_gnt,
    output logic [DW-1:0] disp_rdata,
    output logic          disp_rvalid,
    input  logic          host_req,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_wdata,
    output logic          host_gnt,
    output logic [DW-1:0] host_rdata,
    output logic          host_rvalid,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    typedef enum logic {
        OWN_DISP = 1'b0,
        OWN_HOST = 1'b1
    } owner_t;

    typedef struct packed {
        logic   vld;
        owner_t owner;
    } tag_t;

    localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

    logic [3:0] wait_cnt;
    logic       force_host;
    tag_t       s1;
    tag_t       s2;

    // Grants are held off while in reset so nothing is accepted that would be lost.
    always_comb begin
        force_host = host_req && (wait_cnt == MAX_WAIT_C);
        host_gnt   = reset_in && host_req && (!disp_req || force_host);
        disp_gnt   = reset_in && disp_req && !host_gnt;
    end

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            wait_cnt <= '0;
        end else if (host_gnt || !host_req) begin
            wait_cnt <= '0;
        end else if (wait_cnt != MAX_WAIT_C) begin
            wait_cnt <= wait_cnt + 4'd1;
        end
    end

    // Display never writes, so its grants leave mem_wdata at its last value.
    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            s1        <= '0;
            s2        <= '0;
        end else begin
            s2 <= s1;
            if (host_gnt) begin
                mem_en    <= 1'b1;
                mem_we    <= host_we;
                mem_addr  <= host_addr;
                mem_wdata <= host_wdata;
                s1.vld    <= !host_we;
                s1.owner  <= OWN_HOST;
            end else if (disp_gnt) begin
                mem_en    <= 1'b1;
                mem_we    <= 1'b0;
                mem_addr  <= disp_addr;
                s1.vld    <= 1'b1;
                s1.owner  <= OWN_DISP;
            end else begin
                mem_en    <= 1'b0;
                mem_we    <= 1'b0;
                s1.vld    <= 1'b0;
            end
        end
    end

    assign disp_rvalid = s2.vld && (s2.owner == OWN_DISP);
    assign host_rvalid = s2.vld && (s2.owner == OWN_HOST);
    assign disp_rdata  = mem_rdata;
    assign host_rdata  = mem_rdata;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed bench for vga_fb_arbiter with a behavioural sync RAM and an in-order read-return scoreboard.
module tb_vga_fb_arbiter;

    localparam int AW = 15;
    localparam int DW = 3;

    logic          clk_in = 1'b0;
    logic          reset_in;
    logic          disp_req;
    logic [AW-1:0] disp_addr;
    logic          disp_gnt;
    logic [DW-1:0] disp_rdata;
    logic          disp_rvalid;
    logic          host_req;
    logic          host_we;
    logic [AW-1:0] host_addr;
    logic [DW-1:0] host_wdata;
    logic          host_gnt;
    logic [DW-1:0] host_rdata;
    logic          host_rvalid;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;

    logic [DW-1:0] ram [0:(1<<AW)-1];

    typedef struct {
        logic [DW-1:0] dat;
        int            due;
    } exp_t;

    exp_t disp_q[$];
    exp_t host_q[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    vga_fb_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(4)) dut (
        .clk_in      (clk_in),
        .reset_in    (reset_in),
        .disp_req    (disp_req),
        .disp_addr   (disp_addr),
        .disp_gnt    (disp_gnt),
        .disp_rdata  (disp_rdata),
        .disp_rvalid (disp_rvalid),
        .host_req    (host_req),
        .host_we     (host_we),
        .host_addr   (host_addr),
        .host_wdata  (host_wdata),
        .host_gnt    (host_gnt),
        .host_rdata  (host_rdata),
        .host_rvalid (host_rvalid),
        .mem_en      (mem_en),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) cyc <= cyc + 1;

    // Single-port synchronous RAM, one cycle read latency.
    always @(posedge clk_in) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: grant exclusivity every cycle, and in-order read returns against the scoreboard.
    always @(negedge clk_in) begin
        exp_t e;
        chk("gnt_exclusive", 32'(disp_gnt && host_gnt), 0);
        if (disp_rvalid) begin
            if (disp_q.size() == 0) begin
                chk("disp_rvalid_unexpected", 32'(disp_rvalid), 0);
            end else begin
                e = disp_q.pop_front();
                chk("disp_rdata", 32'(disp_rdata), 32'(e.dat));
                chk("disp_latency", cyc, e.due);
            end
        end
        if (host_rvalid) begin
            if (host_q.size() == 0) begin
                chk("host_rvalid_unexpected", 32'(host_rvalid), 0);
            end else begin
                e = host_q.pop_front();
                chk("host_rdata", 32'(host_rdata), 32'(e.dat));
                chk("host_latency", cyc, e.due);
            end
        end
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic smp();
        @(negedge clk_in);
    endtask

    task automatic push_disp(input logic [DW-1:0] d);
        exp_t e;
        e.dat = d;
        e.due = cyc + 2;
        disp_q.push_back(e);
    endtask

    task automatic push_host(input logic [DW-1:0] d);
        exp_t e;
        e.dat = d;
        e.due = cyc + 2;
        host_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            disp_req = 1'b0;
            host_req = 1'b0;
            smp();
        end
    endtask

    initial begin
        bit exp_h;
        bit hreq;

        // Reset with random requests pending.
        reset_in   = 1'b0;
        disp_req   = 1'b1;
        host_req   = 1'b1;
        host_we    = 1'($urandom);
        disp_addr  = AW'($urandom);
        host_addr  = AW'($urandom);
        host_wdata = DW'($urandom);
        smp();
        smp();
        chk("rst_disp_gnt",    32'(disp_gnt), 0);
        chk("rst_host_gnt",    32'(host_gnt), 0);
        chk("rst_mem_en",      32'(mem_en), 0);
        chk("rst_mem_we",      32'(mem_we), 0);
        chk("rst_mem_addr",    32'(mem_addr), 0);
        chk("rst_mem_wdata",   32'(mem_wdata), 0);
        chk("rst_disp_rvalid", 32'(disp_rvalid), 0);
        chk("rst_host_rvalid", 32'(host_rvalid), 0);
        chk("rst_disp_rdata",  32'(disp_rdata), 0);
        chk("rst_host_rdata",  32'(host_rdata), 0);

        tick();
        reset_in = 1'b1;
        disp_req = 1'b0;
        host_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            smp();
            chk("post_rst_mem_en", 32'(mem_en), 0);
            tick();
        end

        // Host alone: write 1..4 to addresses 0..3, granted every cycle.
        for (int i = 0; i < 5; i++) begin
            if (i > 0) tick();
            if (i < 4) begin
                host_req   = 1'b1;
                host_we    = 1'b1;
                host_addr  = AW'(i);
                host_wdata = DW'(i + 1);
            end else begin
                host_req = 1'b0;
            end
            smp();
            if (i < 4) begin
                chk("host_only_gnt", 32'(host_gnt), 1);
                chk("host_only_disp_gnt", 32'(disp_gnt), 0);
            end
            if (i > 0) begin
                chk("wr_mem_en",    32'(mem_en), 1);
                chk("wr_mem_we",    32'(mem_we), 1);
                chk("wr_mem_addr",  32'(mem_addr), i - 1);
                chk("wr_mem_wdata", 32'(mem_wdata), i);
            end
        end

        // Display stream of addresses 0..3, back-to-back.
        for (int i = 0; i < 6; i++) begin
            tick();
            if (i < 4) begin
                disp_req  = 1'b1;
                disp_addr = AW'(i);
            end else begin
                disp_req = 1'b0;
            end
            smp();
            if (i < 4) begin
                chk("ds_disp_gnt", 32'(disp_gnt), 1);
                push_disp(DW'(i + 1));
            end
            if (i > 0 && i < 5) begin
                chk("ds_mem_en",   32'(mem_en), 1);
                chk("ds_mem_we",   32'(mem_we), 0);
                chk("ds_mem_addr", 32'(mem_addr), i - 1);
            end
            if (i == 5) chk("ds_idle_mem_en", 32'(mem_en), 0);
        end
        idle(2);

        // Host write 0x0010 = 7 then display read of 0x0010 the next cycle.
        tick();
        host_req   = 1'b1;
        host_we    = 1'b1;
        host_addr  = AW'(16);
        host_wdata = 3'b111;
        smp();
        chk("wr_rd_host_gnt", 32'(host_gnt), 1);
        tick();
        host_req  = 1'b0;
        disp_req  = 1'b1;
        disp_addr = AW'(16);
        smp();
        chk("wr_rd_disp_gnt", 32'(disp_gnt), 1);
        push_disp(3'b111);
        chk("wr_rd_mem_we",    32'(mem_we), 1);
        chk("wr_rd_mem_addr",  32'(mem_addr), 16);
        chk("wr_rd_mem_wdata", 32'(mem_wdata), 7);
        tick();
        disp_req = 1'b0;
        smp();
        chk("wr_rd_rd_en", 32'(mem_en), 1);
        chk("wr_rd_rd_we", 32'(mem_we), 0);
        idle(3);

        // Seed address 5 with 2 for the host readbacks below.
        tick();
        host_req   = 1'b1;
        host_we    = 1'b1;
        host_addr  = AW'(5);
        host_wdata = 3'b010;
        smp();
        chk("seed_host_gnt", 32'(host_gnt), 1);
        idle(2);

        // Continuous contention: 4 display grants, then 1 host grant, repeating.
        for (int k = 0; k < 10; k++) begin
            tick();
            disp_req  = 1'b1;
            disp_addr = AW'(2);
            host_req  = 1'b1;
            host_we   = 1'b0;
            host_addr = AW'(5);
            smp();
            exp_h = (k == 4) || (k == 9);
            chk("ct_host_gnt", 32'(host_gnt), 32'(exp_h));
            chk("ct_disp_gnt", 32'(disp_gnt), 32'(!exp_h));
            if (exp_h) push_host(3'b010);
            else       push_disp(3'b011);
        end
        idle(3);

        // Host drops for one cycle while waiting: the wait count restarts.
        for (int k = 0; k < 9; k++) begin
            tick();
            hreq      = (k != 2) && (k <= 7);
            disp_req  = 1'b1;
            disp_addr = AW'(2);
            host_req  = hreq;
            host_we   = 1'b0;
            host_addr = AW'(5);
            smp();
            exp_h = (k == 7);
            chk("drop_host_gnt", 32'(host_gnt), 32'(exp_h));
            chk("drop_disp_gnt", 32'(disp_gnt), 32'(!exp_h));
            if (exp_h) push_host(3'b010);
            else       push_disp(3'b011);
        end
        idle(3);

        // Reset while a display read is in flight: its return is discarded.
        tick();
        disp_req  = 1'b1;
        disp_addr = AW'(1);
        smp();
        chk("mid_rst_gnt", 32'(disp_gnt), 1);
        tick();
        reset_in = 1'b0;
        disp_req = 1'b0;
        smp();
        chk("mid_rst_mem_en", 32'(mem_en), 0);
        chk("mid_rst_rvalid_a", 32'(disp_rvalid), 0);
        tick();
        smp();
        chk("mid_rst_rvalid_b", 32'(disp_rvalid), 0);
        tick();
        reset_in = 1'b1;
        smp();
        chk("mid_rst_rvalid_c", 32'(disp_rvalid), 0);
        tick();
        smp();
        chk("mid_rst_rvalid_d", 32'(disp_rvalid), 0);
        tick();
        disp_req  = 1'b1;
        disp_addr = AW'(3);
        smp();
        chk("post_rst_gnt", 32'(disp_gnt), 1);
        push_disp(3'b100);
        idle(4);

        chk("disp_q_drained", disp_q.size(), 0);
        chk("host_q_drained", host_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
